vga_rect_blitter: RTL and testbench
===================================

// Module: vga_rect_blitter
// PURPOSE
// - Bus-mapped rectangle fill engine upstream of the VGA driver's frame buffer port A.
// - The processor programs the corners, the fill value and a start command.
// - The engine then issues one frame-buffer pixel write per clock until the rectangle is filled.
// - This offloads per-pixel X/Y/data/WE bus traffic from the processor on the 160x120 mono frame.
// PARAMETERS
// - BASE_ADDR  8'hB4  bus address of reg 0; block decodes BASE_ADDR..BASE_ADDR+5
// - X_MAX      159    largest valid X; larger coordinates are clamped at start
// - Y_MAX      119    largest valid Y; larger coordinates are clamped at start
// PORTS
// - CLK        in     1   system clock, 100 MHz
// - RESET_N    in     1   asynchronous active-low reset
// - BUS_DATA   inout  8   shared data bus; driven only during a decoded read
// - BUS_ADDR   in     8   bus address
// - BUS_WE     in     1   1 = processor write, 0 = read
// - FB_ADDR    out    15  {Y[6:0], X[7:0]} to frame buffer port A
// - FB_DATA    out    1   pixel value to write
// - FB_WE      out    1   frame buffer write strobe, one pixel per cycle
// - BUSY       out    1   high while the fill is in progress
// BEHAVIOUR
// - Register map (offset from BASE_ADDR):
//   - 0 X0, 1 Y0, 2 X1, 3 Y1: R/W.
//   - 4 CTRL: W only.
//     - bit0 START
//     - bit1 FILL value
//     - bit2 ABORT
//     - Reads return {6'b0, FILL, 1'b0}.
//   - 5 STATUS: R only; reads return {5'b0, ERR, DONE, BUSY}.
// - Bus reads are registered. BUS_DATA is driven the cycle after a decoded read address is presented.
// - BUS_DATA is Z otherwise, and Z whenever BUS_WE=1.
// - Reset (async, RESET_N=0): all registers are 0 and the FSM is IDLE.
//   - FB_WE, BUSY, DONE and ERR are 0 immediately, not on the next edge.
//   - BUS_DATA is released to Z.
// - FSM states IDLE, FILL.
//   - IDLE -> FILL: on a START write, if X0<=X1 and Y0<=Y1 after clamping.
//     - Sets the cursor to (X0,Y0) and BUSY=1 on the next edge.
//     - Clears DONE and ERR.
//   - START with X0>X1 or Y0>Y1: stays IDLE, ERR=1 on the next edge, no FB_WE.
//   - FILL: FB_WE=1 every cycle.
//     - FB_ADDR is the cursor; FB_DATA is FILL as latched at START.
//     - Cursor X increments; when X==X1, X reloads X0 and Y increments.
//   - FILL -> IDLE: after the write of (X1,Y1). BUSY=0 and DONE=1 on the following edge.
//   - FILL -> IDLE on an ABORT write: FB_WE=0 from the next edge and DONE stays 0.
//     - ABORT takes priority over START in the same write.
// - Latency: START written at edge N gives the first FB_WE in cycle N+1.
//   - Total write cycles = (X1-X0+1)*(Y1-Y0+1).
//   - The worst case is 19200 cycles.
// - While BUSY: writes to offsets 0-3 and START are ignored. FILL writes to CTRL are also ignored.
// - Coordinates are clamped at START: X>X_MAX uses X_MAX, Y>Y_MAX uses Y_MAX.
//   - Stored register values are not changed.
// - The cursor never wraps: the last write of a fill is always (X1,Y1).
// - The 8-bit X and 7-bit Y counters must not overflow at X_MAX/Y_MAX.
// - FB_ADDR holds its last value when FB_WE=0. After reset FB_ADDR=0.
// CONFIGURATION
// - VGA_BLIT_IRQ_EN defined: adds output IRQ_DONE (1 bit).
//   - IRQ_DONE is a one-cycle pulse on the edge DONE rises.
//   - It is not asserted on ABORT or ERR, and is 0 in reset.
// - Undefined: no IRQ_DONE port. Software polls STATUS.
// TESTING
// - Reset mid-fill: RESET_N=0 during FILL -> FB_WE=0 and BUSY=0 combinationally; STATUS reads 0 after release.
// - Fill 2x2: write X0=10, Y0=5, X1=11, Y1=6, CTRL=8'h03.
//   - Expect 4 FB_WE cycles with FB_DATA=1 at {5,10}, {5,11}, {6,10}, {6,11}.
//   - Then STATUS=8'h02.
// - Single pixel: X0=X1=0, Y0=Y1=0, CTRL=8'h01.
//   - Expect exactly 1 FB_WE at FB_ADDR=0 with FB_DATA=0.
//   - BUSY is high for 1 cycle.
// - Clamp: X0=150, X1=200, Y0=Y1=119, START.
//   - Expect 10 writes, X 150..159 at Y 119, then DONE.
// - Error and abort:
//   - X0=20, X1=10, START -> STATUS=8'h04 and no writes.
//   - Full-screen START, then ABORT after 100 writes -> exactly 100 FB_WE cycles and STATUS=8'h00.
// - Bus: read offset 1 after writing 8'h2A -> BUS_DATA=8'h2A one cycle after the address; address 8'hB0 -> BUS_DATA stays Z.

Source files
------------

// File: rtl/vga_rect_blitter.sv
// Bus-mapped rectangle fill engine: writes one frame-buffer pixel per clock over a clamped rectangle.
// Optional feature: define VGA_BLIT_IRQ_EN to add the IRQ_DONE completion pulse output.
module vga_rect_blitter #(
  parameter logic [7:0] BASE_ADDR = 8'hB4,
  parameter int         X_MAX     = 159,
  parameter int         Y_MAX     = 119
) (
  input  logic        CLK,
  input  logic        RESET_N,
  inout  wire  [7:0]  BUS_DATA,
  input  logic [7:0]  BUS_ADDR,
  input  logic        BUS_WE,
  output logic [14:0] FB_ADDR,
  output logic        FB_DATA,
  output logic        FB_WE,
  output logic        BUSY
`ifdef VGA_BLIT_IRQ_EN
  ,
  output logic        IRQ_DONE
`endif
);

  localparam logic [7:0] X_LIM = X_MAX[7:0];
  localparam logic [7:0] Y_LIM = Y_MAX[7:0];

  typedef enum logic {
    IDLE,
    FILL
  } state_t;

  state_t state, next_state;

  logic [7:0] x0_r, y0_r, x1_r, y1_r;
  logic       fill_r;
  logic       done_r;
  logic       err_r;
  logic [7:0] cur_x;
  logic [6:0] cur_y;
  logic       fb_data_r;
  logic [7:0] rd_q;
  logic       rd_oe;
  logic [7:0] rd_next;

  // Bus decode: offsets below BASE_ADDR wrap to large values and miss.
  logic [7:0] offset;
  logic       hit;
  logic       wr_ctrl;
  logic       cmd_start;
  logic       cmd_abort;

  assign offset    = BUS_ADDR - BASE_ADDR;
  assign hit       = (offset < 8'd6);
  assign wr_ctrl   = BUS_WE && hit && (offset == 8'd4);
  assign cmd_start = wr_ctrl && BUS_DATA[0];
  assign cmd_abort = wr_ctrl && BUS_DATA[2];

  // Clamped corners; the stored registers keep whatever software wrote.
  logic [7:0] clx0, clx1;
  logic [6:0] cly0, cly1;
  logic       rect_ok;
  logic       last_x;
  logic       last_px;

  assign clx0    = (x0_r > X_LIM) ? X_LIM : x0_r;
  assign clx1    = (x1_r > X_LIM) ? X_LIM : x1_r;
  assign cly0    = (y0_r > Y_LIM) ? Y_LIM[6:0] : y0_r[6:0];
  assign cly1    = (y1_r > Y_LIM) ? Y_LIM[6:0] : y1_r[6:0];
  assign rect_ok = (clx0 <= clx1) && (cly0 <= cly1);
  assign last_x  = (cur_x == clx1);
  assign last_px = last_x && (cur_y == cly1);

  logic start_ok;
  logic start_err;
  logic advance;
  logic finish;

  always_ff @(posedge CLK or negedge RESET_N) begin
    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    if (!RESET_N) state <= IDLE;
    else          state <= next_state;
  end

  always_comb begin
    // NOTE: every output of this block gets a default first, so no path can infer a latch.
    next_state = state;
    start_ok   = 1'b0;
    start_err  = 1'b0;
    advance    = 1'b0;
    finish     = 1'b0;
    case (state)
      IDLE: begin
        if (cmd_start && !cmd_abort) begin
          if (rect_ok) begin
            start_ok   = 1'b1;
            next_state = FILL;
          end else begin
            start_err  = 1'b1;
          end
        end
      end
      FILL: begin
        if (cmd_abort) begin
          next_state = IDLE;
        end else if (last_px) begin
          finish     = 1'b1;
          next_state = IDLE;
        end else begin
          advance    = 1'b1;
        end
      end
      default: next_state = IDLE;
    endcase
  end

  assign BUSY    = (state == FILL);
  assign FB_WE   = (state == FILL);
  assign FB_ADDR = {cur_y, cur_x};
  assign FB_DATA = fb_data_r;

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      x0_r      <= '0;
      y0_r      <= '0;
      x1_r      <= '0;
      y1_r      <= '0;
      fill_r    <= 1'b0;
      done_r    <= 1'b0;
      err_r     <= 1'b0;
      cur_x     <= '0;
      cur_y     <= '0;
      fb_data_r <= 1'b0;
    end else begin
      if (BUS_WE && hit && (state == IDLE)) begin
        case (offset)
          8'd0:    x0_r   <= BUS_DATA;
          8'd1:    y0_r   <= BUS_DATA;
          8'd2:    x1_r   <= BUS_DATA;
          8'd3:    y1_r   <= BUS_DATA;
          8'd4:    fill_r <= BUS_DATA[1];
          default: ;
        endcase
      end

      // Cursor is left untouched on the final write and on abort so FB_ADDR holds.
      if (start_ok) begin
        done_r    <= 1'b0;
        err_r     <= 1'b0;
        cur_x     <= clx0;
        cur_y     <= cly0;
        fb_data_r <= BUS_DATA[1];
      end else if (start_err) begin
        done_r    <= 1'b0;
        err_r     <= 1'b1;
      end else if (advance) begin
        if (last_x) begin
          cur_x <= clx0;
          cur_y <= cur_y + 7'd1;
        end else begin
          cur_x <= cur_x + 8'd1;
        end
      end else if (finish) begin
        done_r <= 1'b1;
      end
    end
  end

  always_comb begin
    rd_next = '0;
    case (offset)
      8'd0:    rd_next = x0_r;
      8'd1:    rd_next = y0_r;
      8'd2:    rd_next = x1_r;
      8'd3:    rd_next = y1_r;
      8'd4:    rd_next = {6'b0, fill_r, 1'b0};
      8'd5:    rd_next = {5'b0, err_r, done_r, BUSY};
      default: rd_next = '0;
    endcase
  end

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      rd_oe <= 1'b0;
      rd_q  <= '0;
    end else begin
      rd_oe <= !BUS_WE && hit;
      if (!BUS_WE && hit) rd_q <= rd_next;
    end
  end

  // Gating with the live BUS_WE keeps the bus free the moment the processor starts driving.
  assign BUS_DATA = (rd_oe && !BUS_WE) ? rd_q : 8'hzz;

`ifdef VGA_BLIT_IRQ_EN
  logic irq_r;

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) irq_r <= 1'b0;
    else          irq_r <= finish;
  end

  assign IRQ_DONE = irq_r;
`endif

endmodule

// File: tb/tb_vga_rect_blitter.sv
// Directed self-checking bench for vga_rect_blitter: bus access, fills, clamping, error, abort, reset.
module tb_vga_rect_blitter;

  localparam logic [7:0] BASE = 8'hB4;

  logic        CLK;
  logic        RESET_N;
  wire  [7:0]  bus_data;
  logic [7:0]  tb_dout;
  logic        tb_oe;
  logic [7:0]  bus_addr;
  logic        bus_we;
  logic [14:0] fb_addr;
  logic        fb_data;
  logic        fb_we;
  logic        busy;
  logic        irq_done;

  int n_checks;
  int n_fail;
  int wr_count;
  int busy_cycles;
  int irq_count;
  logic [14:0] wr_addr[$];
  logic        wr_dat[$];
  logic [7:0]  rd;

  assign bus_data = tb_oe ? tb_dout : 8'hzz;

  vga_rect_blitter #(.BASE_ADDR(BASE), .X_MAX(159), .Y_MAX(119)) dut (
    .CLK      (CLK),
    .RESET_N  (RESET_N),
    .BUS_DATA (bus_data),
    .BUS_ADDR (bus_addr),
    .BUS_WE   (bus_we),
    .FB_ADDR  (fb_addr),
    .FB_DATA  (fb_data),
    .FB_WE    (fb_we),
    .BUSY     (busy)
`ifdef VGA_BLIT_IRQ_EN
    ,
    .IRQ_DONE (irq_done)
`endif
  );

`ifndef VGA_BLIT_IRQ_EN
  assign irq_done = 1'b0;
`endif

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // A two-state simulator reads an undriven net as 0, a four-state one as z.
  function automatic logic released(input logic [7:0] v);
    return (v === 8'hzz) || (v === 8'h00);
  endfunction

  task automatic clear_log();
    wr_count    = 0;
    busy_cycles = 0;
    irq_count   = 0;
    wr_addr.delete();
    wr_dat.delete();
  endtask

  // Log the current cycle, then advance to 1 ns after the next rising edge.
  task automatic step();
    if (fb_we === 1'b1) begin
      wr_count++;
      wr_addr.push_back(fb_addr);
      wr_dat.push_back(fb_data);
    end
    if (busy === 1'b1) busy_cycles++;
    if (irq_done === 1'b1) irq_count++;
    @(posedge CLK);
    #1;
  endtask

  task automatic bus_write(input logic [7:0] off, input logic [7:0] val);
    bus_addr = BASE + off;
    bus_we   = 1'b1;
    tb_dout  = val;
    tb_oe    = 1'b1;
    step();
    bus_we   = 1'b0;
    tb_oe    = 1'b0;
    bus_addr = 8'h00;
  endtask

  task automatic bus_read(input logic [7:0] off, output logic [7:0] val);
    bus_addr = BASE + off;
    bus_we   = 1'b0;
    step();
    val      = bus_data;
    bus_addr = 8'h00;
  endtask

  task automatic set_rect(input logic [7:0] x0, input logic [7:0] y0,
                          input logic [7:0] x1, input logic [7:0] y1);
    bus_write(8'd0, x0);
    bus_write(8'd1, y0);
    bus_write(8'd2, x1);
    bus_write(8'd3, y1);
  endtask

  task automatic wait_idle(input int budget, input string tag);
    int n;
    n = 0;
    while (busy === 1'b1 && n < budget) begin
      step();
      n++;
    end
    check(tag, {31'b0, busy}, 32'd0);
  endtask

  initial begin
    logic [14:0] exp_2x2 [4];
    exp_2x2[0] = 15'h050A;
    exp_2x2[1] = 15'h050B;
    exp_2x2[2] = 15'h060A;
    exp_2x2[3] = 15'h060B;

    n_checks = 0;
    n_fail   = 0;
    clear_log();
    RESET_N  = 1'b0;
    bus_we   = 1'b0;
    tb_oe    = 1'b0;
    tb_dout  = 8'h00;
    bus_addr = 8'h00;

    #1;
    check("reset_fb_we",   {31'b0, fb_we}, 32'd0);
    check("reset_busy",    {31'b0, busy}, 32'd0);
    check("reset_fb_addr", {17'b0, fb_addr}, 32'd0);
    check("reset_bus_z",   {31'b0, released(bus_data)}, 32'd1);
    @(posedge CLK);
    @(posedge CLK);
    #2 RESET_N = 1'b1;
    @(posedge CLK);
    #1;
    bus_read(8'd5, rd);
    check("reset_status", {24'b0, rd}, 32'h00);

    // Registered read, release while BUS_WE=1, and an out-of-range address.
    bus_write(8'd1, 8'h2A);
    bus_addr = BASE + 8'd1;
    bus_we   = 1'b0;
    #1;
    check("read_not_yet_driven", {31'b0, released(bus_data)}, 32'd1);
    @(posedge CLK);
    #1;
    check("read_y0", {24'b0, bus_data}, 32'h2A);
    bus_we = 1'b1;
    #1;
    check("read_z_on_we", {31'b0, released(bus_data)}, 32'd1);
    bus_we   = 1'b0;
    bus_addr = 8'hB0;
    step();
    check("read_b0_z", {31'b0, released(bus_data)}, 32'd1);
    bus_addr = 8'h00;

    // 2x2 fill with FILL=1.
    set_rect(8'd10, 8'd5, 8'd11, 8'd6);
    clear_log();
    bus_write(8'd4, 8'h03);
    check("fill2_first_we", {31'b0, fb_we}, 32'd1);
    wait_idle(20, "fill2_timeout");
    check("fill2_count", wr_count, 32'd4);
    for (int i = 0; i < 4; i++) begin
      check($sformatf("fill2_addr%0d", i), {17'b0, wr_addr[i]}, {17'b0, exp_2x2[i]});
      check($sformatf("fill2_data%0d", i), {31'b0, wr_dat[i]}, 32'd1);
    end
`ifdef VGA_BLIT_IRQ_EN
    check("fill2_irq_pulses", irq_count, 32'd1);
`endif
    bus_read(8'd5, rd);
    check("fill2_status", {24'b0, rd}, 32'h02);
    bus_read(8'd4, rd);
    check("fill2_ctrl_rd", {24'b0, rd}, 32'h02);

    // Single pixel with FILL=0.
    set_rect(8'd0, 8'd0, 8'd0, 8'd0);
    clear_log();
    bus_write(8'd4, 8'h01);
    wait_idle(10, "single_timeout");
    check("single_count", wr_count, 32'd1);
    check("single_addr", {17'b0, wr_addr[0]}, 32'd0);
    check("single_data", {31'b0, wr_dat[0]}, 32'd0);
    check("single_busy_cycles", busy_cycles, 32'd1);

    // Clamp: X1=200 behaves as 159.
    set_rect(8'd150, 8'd119, 8'd200, 8'd119);
    clear_log();
    bus_write(8'd4, 8'h03);
    wait_idle(100, "clamp_timeout");
    check("clamp_count", wr_count, 32'd10);
    check("clamp_first", {17'b0, wr_addr[0]}, 32'h7796);
    check("clamp_last", {17'b0, wr_addr[9]}, 32'h779F);
    bus_read(8'd5, rd);
    check("clamp_status", {24'b0, rd}, 32'h02);
    bus_read(8'd2, rd);
    check("clamp_x1_kept", {24'b0, rd}, 32'hC8);

    // Inverted rectangle.
    bus_write(8'd0, 8'd20);
    bus_write(8'd2, 8'd10);
    clear_log();
    bus_write(8'd4, 8'h01);
    check("err_busy", {31'b0, busy}, 32'd0);
    bus_read(8'd5, rd);
    check("err_status", {24'b0, rd}, 32'h04);
    step();
    check("err_no_writes", wr_count, 32'd0);

    // Full screen, busy-time writes ignored, abort after exactly 100 writes.
    set_rect(8'd0, 8'd0, 8'd159, 8'd119);
    clear_log();
    bus_write(8'd4, 8'h01);
    for (int i = 0; i < 49; i++) step();
    bus_write(8'd2, 8'h05);
    bus_write(8'd4, 8'h02);
    for (int i = 0; i < 48; i++) step();
    bus_write(8'd4, 8'h05);
    check("abort_fb_we", {31'b0, fb_we}, 32'd0);
    check("abort_busy", {31'b0, busy}, 32'd0);
    for (int i = 0; i < 5; i++) step();
    check("abort_count", wr_count, 32'd100);
    check("abort_last_addr", {17'b0, wr_addr[99]}, 32'h0063);
    check("abort_addr_hold", {17'b0, fb_addr}, 32'h0063);
    check("abort_data", {31'b0, wr_dat[60]}, 32'd0);
    bus_read(8'd5, rd);
    check("abort_status", {24'b0, rd}, 32'h00);
    bus_read(8'd2, rd);
    check("busy_x1_ignored", {24'b0, rd}, 32'h9F);
    bus_read(8'd4, rd);
    check("busy_fill_ignored", {24'b0, rd}, 32'h00);

    // ABORT together with START while idle does not start.
    clear_log();
    bus_write(8'd4, 8'h05);
    check("abort_start_prio", {31'b0, busy}, 32'd0);
    step();
    check("abort_start_no_wr", wr_count, 32'd0);

    // Asynchronous reset in the middle of a fill.
    bus_write(8'd4, 8'h01);
    for (int i = 0; i < 10; i++) step();
    check("midfill_busy", {31'b0, busy}, 32'd1);
    #2 RESET_N = 1'b0;
    #1;
    check("midreset_fb_we", {31'b0, fb_we}, 32'd0);
    check("midreset_busy", {31'b0, busy}, 32'd0);
    check("midreset_fb_addr", {17'b0, fb_addr}, 32'd0);
    @(posedge CLK);
    #3 RESET_N = 1'b1;
    @(posedge CLK);
    #1;
    bus_read(8'd5, rd);
    check("midreset_status", {24'b0, rd}, 32'h00);
    bus_read(8'd2, rd);
    check("midreset_x1", {24'b0, rd}, 32'h00);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
